// File: rtl/uart_param_receiver.sv
// uart_param_receiver: 8N1 UART byte receiver plus 4-byte parameter packet
// parser (header, r1, r2, xor checksum) driving registered odometry params.
module uart_param_receiver #(
    parameter int          CLKS_PER_BIT = 104,
    parameter logic [7:0]  HEADER       = 8'hA5,
    parameter logic [7:0]  RESET_PARAM  = 8'd127,
    parameter int          TIMEOUT_BITS = 20
) (
    input  logic       CLK,
    input  logic       rst_n,
    input  logic       uart_rx,
    output logic [7:0] param_r1,
    output logic [7:0] param_r2,
    output logic       params_valid,
    output logic [7:0] rx_byte,
    output logic       rx_byte_valid,
    output logic       frame_error,
    output logic       checksum_error
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

    localparam int TO_LIMIT = TIMEOUT_BITS * CLKS_PER_BIT;
    localparam int TW       = $clog2(TO_LIMIT + 1);
    localparam logic [TW-1:0] TO_LAST = TW'(TO_LIMIT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_WAIT_HIGH
    } bstate_t;

    typedef enum logic [1:0] {
        P_HDR,
        P_R1,
        P_R2,
        P_CHK
    } pstate_t;

    logic          rx_meta_q;
    logic          rxs_q;
    logic          rxs_prev_q;

    bstate_t       bst_q;
    logic [CW-1:0] clk_cnt_q;
    logic [2:0]    bit_cnt_q;
    logic [7:0]    shift_q;
    logic [7:0]    rx_byte_q;
    logic          rx_byte_valid_q;
    logic          frame_error_q;

    pstate_t       pst_q;
    logic [7:0]    r1_tmp_q;
    logic [7:0]    r2_tmp_q;
    logic [TW-1:0] to_cnt_q;
    logic [7:0]    param_r1_q;
    logic [7:0]    param_r2_q;
    logic          params_valid_q;
    logic          checksum_error_q;

    logic [7:0]    chk_d;

    assign chk_d = HEADER ^ r1_tmp_q ^ r2_tmp_q;

    // Two-flop synchroniser for the async line, plus a delayed copy for edges.
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_q  <= 1'b1;
            rxs_q      <= 1'b1;
            rxs_prev_q <= 1'b1;
        end else begin
            rx_meta_q  <= uart_rx;
            rxs_q      <= rx_meta_q;
            rxs_prev_q <= rxs_q;
        end
    end

    // Byte FSM: mid-bit sampling of start, 8 data bits LSB first, and stop.
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            bst_q           <= S_IDLE;
            clk_cnt_q       <= '0;
            bit_cnt_q       <= '0;
            shift_q         <= '0;
            rx_byte_q       <= '0;
            rx_byte_valid_q <= 1'b0;
            frame_error_q   <= 1'b0;
        end else begin
            rx_byte_valid_q <= 1'b0;
            frame_error_q   <= 1'b0;
            unique case (bst_q)
                S_IDLE: begin
                    if (!rxs_q && rxs_prev_q) begin
                        bst_q     <= S_START;
                        clk_cnt_q <= '0;
                        bit_cnt_q <= '0;
                    end
                end
                S_START: begin
                    if (clk_cnt_q == HALF_LAST) begin
                        clk_cnt_q <= '0;
                        bst_q     <= rxs_q ? S_IDLE : S_DATA;
                    end else begin
                        clk_cnt_q <= clk_cnt_q + 1'b1;
                    end
                end
                S_DATA: begin
                    if (clk_cnt_q == BIT_LAST) begin
                        clk_cnt_q <= '0;
                        shift_q   <= {rxs_q, shift_q[7:1]};
                        if (bit_cnt_q == 3'd7) begin
                            bst_q <= S_STOP;
                        end else begin
                            bit_cnt_q <= bit_cnt_q + 1'b1;
                        end
                    end else begin
                        clk_cnt_q <= clk_cnt_q + 1'b1;
                    end
                end
                S_STOP: begin
                    if (clk_cnt_q == BIT_LAST) begin
                        clk_cnt_q <= '0;
                        bit_cnt_q <= '0;
                        if (rxs_q) begin
                            rx_byte_q       <= shift_q;
                            rx_byte_valid_q <= 1'b1;
                            bst_q           <= S_IDLE;
                        end else begin
                            frame_error_q <= 1'b1;
                            bst_q         <= S_WAIT_HIGH;
                        end
                    end else begin
                        clk_cnt_q <= clk_cnt_q + 1'b1;
                    end
                end
                S_WAIT_HIGH: begin
                    if (rxs_q) begin
                        bst_q <= S_IDLE;
                    end
                end
                default: begin
                    bst_q <= S_IDLE;
                end
            endcase
        end
    end

    // Packet FSM: header/r1/r2/checksum, aborted by frame errors or gaps.
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            pst_q            <= P_HDR;
            r1_tmp_q         <= '0;
            r2_tmp_q         <= '0;
            to_cnt_q         <= '0;
            param_r1_q       <= RESET_PARAM;
            param_r2_q       <= RESET_PARAM;
            params_valid_q   <= 1'b0;
            checksum_error_q <= 1'b0;
        end else begin
            params_valid_q   <= 1'b0;
            checksum_error_q <= 1'b0;
            if (rx_byte_valid_q) begin
                to_cnt_q <= '0;
                unique case (pst_q)
                    P_HDR: begin
                        if (rx_byte_q == HEADER) begin
                            pst_q <= P_R1;
                        end
                    end
                    P_R1: begin
                        r1_tmp_q <= rx_byte_q;
                        pst_q    <= P_R2;
                    end
                    P_R2: begin
                        r2_tmp_q <= rx_byte_q;
                        pst_q    <= P_CHK;
                    end
                    P_CHK: begin
                        if (rx_byte_q == chk_d) begin
                            param_r1_q     <= r1_tmp_q;
                            param_r2_q     <= r2_tmp_q;
                            params_valid_q <= 1'b1;
                        end else begin
                            checksum_error_q <= 1'b1;
                        end
                        pst_q <= P_HDR;
                    end
                    default: begin
                        pst_q <= P_HDR;
                    end
                endcase
            end else if (pst_q != P_HDR) begin
                if (frame_error_q || to_cnt_q == TO_LAST) begin
                    pst_q    <= P_HDR;
                    to_cnt_q <= '0;
                    r1_tmp_q <= '0;
                    r2_tmp_q <= '0;
                end else begin
                    to_cnt_q <= to_cnt_q + 1'b1;
                end
            end else begin
                to_cnt_q <= '0;
            end
        end
    end

    assign param_r1       = param_r1_q;
    assign param_r2       = param_r2_q;
    assign params_valid   = params_valid_q;
    assign rx_byte        = rx_byte_q;
    assign rx_byte_valid  = rx_byte_valid_q;
    assign frame_error    = frame_error_q;
    assign checksum_error = checksum_error_q;

endmodule

// File: doc/uart_param_receiver.md
Name: uart_param_receiver

Overview:
- Receive end of the odometry parameter link; the counterpart of the UART transmitter that sends pulse counts to the host.
- Deserialises 8N1 UART bytes from the host on uart_rx.
- Parses a 4-byte parameter packet: header, r1, r2, checksum.
- Presents validated parameters as registered outputs that feed coordinate_calculation in place of the hardwired constant.

Parameters:
- CLKS_PER_BIT, 104, CLK cycles per UART bit (12 MHz / 115200); minimum 8.
- HEADER, 8'hA5, packet start byte.
- RESET_PARAM, 8'd127, reset value of param_r1 and param_r2.
- TIMEOUT_BITS, 20, inter-byte gap in bit periods that aborts a partial packet.

Ports:
- CLK  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- uart_rx  input  1  serial line; idles high; asynchronous to CLK.
- param_r1  output  8  last validated r1.
- param_r2  output  8  last validated r2.
- params_valid  output  1  one-cycle pulse when param_r1/param_r2 update.
- rx_byte  output  8  last correctly framed byte.
- rx_byte_valid  output  1  one-cycle pulse when rx_byte updates.
- frame_error  output  1  one-cycle pulse on bad stop bit.
- checksum_error  output  1  one-cycle pulse on packet checksum mismatch.

Behaviour:
- Reset (async assert, sync deassert use):
  - param_r1 = param_r2 = RESET_PARAM; rx_byte = 0.
  - All pulse outputs = 0.
  - Both FSMs return to idle; all counters = 0.
  - The synchroniser flops reset to 1.
  - Reset mid-byte or mid-packet discards partial data; params keep their reset value.
- Input conditioning: uart_rx passes through a 2-FF synchroniser. All sampling uses the synchronised signal rxs.
- Byte FSM, states IDLE, START, DATA, STOP, WAIT_HIGH:
  - IDLE: a falling edge of rxs (1 -> 0) goes to START and clears the bit counter.
  - START: at CLKS_PER_BIT/2 cycles, if rxs = 0, go to DATA. If rxs = 1, treat as a glitch and go to IDLE with no output.
  - DATA: sample rxs every CLKS_PER_BIT cycles, 8 samples, LSB first, into a shift register. Then go to STOP.
  - STOP: sample at CLKS_PER_BIT after the last data sample.
    - rxs = 1: rx_byte <= shift register, pulse rx_byte_valid, go to IDLE.
    - rxs = 0: pulse frame_error, drop the byte, go to WAIT_HIGH.
  - WAIT_HIGH: stay until rxs = 1, then go to IDLE. A break condition never produces bytes.
  - Latency: rx_byte_valid rises 9.5*CLKS_PER_BIT + 2..3 cycles after the uart_rx falling edge.
  - Back-to-back bytes with no idle time between the stop bit and the next start bit are received without loss.
- Packet FSM, states P_HDR, P_R1, P_R2, P_CHK; advances only on rx_byte_valid:
  - P_HDR: a byte equal to HEADER goes to P_R1. Any other byte is ignored.
  - P_R1: latch r1_tmp, go to P_R2. A byte equal to HEADER here is data, with no resync.
  - P_R2: latch r2_tmp, go to P_CHK.
  - P_CHK: required checksum = HEADER ^ r1_tmp ^ r2_tmp.
    - Match: on the next cycle, param_r1 <= r1_tmp, param_r2 <= r2_tmp, and params_valid pulses in that same cycle.
    - Mismatch: checksum_error pulses; params are unchanged.
    - Either way, return to P_HDR.
  - frame_error in any state other than P_HDR returns the FSM to P_HDR; temporaries are discarded.
  - Timeout: while not in P_HDR, a counter increments every cycle and clears on rx_byte_valid. At TIMEOUT_BITS*CLKS_PER_BIT, return to P_HDR silently, with no error pulse.
  - Simultaneous timeout expiry and rx_byte_valid: the byte wins and the counter clears.
- Width rules:
  - Counters are sized with $clog2 of their terminal values.
  - The checksum is 8-bit XOR, no carry.
  - params_valid and checksum_error are mutually exclusive.

Test Plan (bench overrides CLKS_PER_BIT = 8):
- Reset only, idle line -> param_r1 = param_r2 = 127, no pulses for 1000 cycles.
- Send A5, 10, 20, checksum A5^10^20 = 95 -> four rx_byte_valid pulses; then one params_valid; param_r1 = 8'h10, param_r2 = 8'h20.
- Send A5, 10, 20, 00 -> checksum_error pulses once; params remain 127/127; a following valid packet A5, 33, 44, D2 updates to 33/44.
- Byte 55 with stop bit forced 0, then line high, then a valid packet -> one frame_error, no rx_byte_valid for 55, the packet is accepted.
- Send A5, 10, then idle 25 bit periods, then 20, 95 -> timeout discards the partial packet; no params_valid and no checksum_error; params unchanged.
- 2-cycle low glitch on idle uart_rx -> no rx_byte_valid and no frame_error.
- Assert rst_n low in the middle of r2 -> outputs return to reset values immediately; a subsequent full packet is accepted.
